mac8_dot_seq: RTL and testbench

- Job sequencer that drives one 8-bit MAC slice (the eFPGA math-block 8-bit MAC with a 24-bit accumulator) through a complete dot-product job.
- Per job it latches a configuration, streams N operand/coefficient pairs into the MAC with a valid/ready handshake, and seeds the accumulator on the first term (clear or round).
- After the last term it waits for the MAC output to settle, captures the selected/saturated 8-bit result and holds it on a valid/ready result port.
- Sits between eFPGA fabric logic (or a DMA front end) and the MAC slice. It owns every MAC control input except the MAC's own async reset.

---
 rtl/mac8_dot_seq.sv | 193 +++++++++++++++++++
 tb/tb_mac8_dot_seq.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac8_dot_seq.sv
// mac8_dot_seq: job sequencer for one 8-bit MAC slice with a 24-bit accumulator.
// Latches a job configuration, streams N operand/coefficient pairs into the MAC,
// seeds the accumulator on the first term (clear or round), waits one cycle for
// the MAC output to settle, then holds the captured 8-bit result on a
// valid/ready port until it is taken.
module mac8_dot_seq #(
  parameter int LEN_W = 8
) (
  input  logic             MAC_ACC_CLK,
  input  logic             MAC_ACC_RST,
  // job request / configuration
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [LEN_W-1:0] cfg_len_m1,
  input  logic [5:0]       cfg_out_sel,
  input  logic             cfg_sat,
  input  logic             cfg_tc,
  input  logic             cfg_rnd,
  input  logic             abort,
  // operand stream
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_oper,
  input  logic [7:0]       in_coef,
  // result port
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic             busy,
  // MAC slice control
  output logic [7:0]       MAC_OPER_DATA,
  output logic [7:0]       MAC_COEF_DATA,
  output logic             EFPGA_MATHB_CLK_EN,
  output logic             MAC_ACC_CLEAR,
  output logic             MAC_ACC_RND,
  output logic             MAC_ACC_SAT,
  output logic [5:0]       MAC_OUT_SEL,
  output logic             MAC_TC,
  input  logic [7:0]       MAC_OUT
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_next_s;

  // latched job configuration, stable for the whole job
  logic [LEN_W-1:0] len_m1_r;
  logic [5:0]       out_sel_r;
  logic             sat_r;
  logic             tc_r;
  logic             rnd_r;

  // one extra bit so the count can never wrap before the final compare
  logic [LEN_W:0]   cnt_r;
  logic [7:0]       res_data_r;

  logic             kill_s;
  logic             start_fire_s;
  logic             accept_s;
  logic             first_beat_s;
  logic             last_beat_s;
  logic             capture_s;

  // Handshake decode; abort and reset both suppress any MAC strobe this cycle
  always_comb begin
    kill_s       = abort | MAC_ACC_RST;
    start_fire_s = (state_r == S_IDLE) & start_valid;
    accept_s     = (state_r == S_RUN) & in_valid & ~kill_s;
    first_beat_s = accept_s & (cnt_r == {(LEN_W+1){1'b0}});
    last_beat_s  = accept_s & (cnt_r == {1'b0, len_m1_r});
    capture_s    = (state_r == S_DRAIN) & ~kill_s;
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start_valid) begin
          state_next_s = S_RUN;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_next_s = S_IDLE;
        end else if (last_beat_s) begin
          state_next_s = S_DRAIN;
        end else begin
          state_next_s = S_RUN;
        end
      end
      S_DRAIN: begin
        if (abort) begin
          state_next_s = S_IDLE;
        end else begin
          state_next_s = S_DONE;
        end
      end
      S_DONE: begin
        if (abort || res_ready) begin
          state_next_s = S_IDLE;
        end else begin
          state_next_s = S_DONE;
        end
      end
      default: begin
        state_next_s = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge MAC_ACC_CLK) begin
    if (MAC_ACC_RST) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Configuration latch, loaded only when a job is accepted
  always_ff @(posedge MAC_ACC_CLK) begin
    if (MAC_ACC_RST) begin
      len_m1_r  <= {LEN_W{1'b0}};
      out_sel_r <= 6'd0;
      sat_r     <= 1'b0;
      tc_r      <= 1'b0;
      rnd_r     <= 1'b0;
    end else if (start_fire_s) begin
      len_m1_r  <= cfg_len_m1;
      out_sel_r <= cfg_out_sel;
      sat_r     <= cfg_sat;
      tc_r      <= cfg_tc;
      rnd_r     <= cfg_rnd;
    end else begin
      len_m1_r  <= len_m1_r;
      out_sel_r <= out_sel_r;
      sat_r     <= sat_r;
      tc_r      <= tc_r;
      rnd_r     <= rnd_r;
    end
  end

  // Term counter: zeroed at job start, advanced on each accepted beat
  always_ff @(posedge MAC_ACC_CLK) begin
    if (MAC_ACC_RST) begin
      cnt_r <= {(LEN_W+1){1'b0}};
    end else if (start_fire_s) begin
      cnt_r <= {(LEN_W+1){1'b0}};
    end else if (accept_s) begin
      cnt_r <= cnt_r + {{LEN_W{1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Result capture at the end of the settle cycle; held through DONE
  always_ff @(posedge MAC_ACC_CLK) begin
    if (MAC_ACC_RST) begin
      res_data_r <= 8'd0;
    end else if (capture_s) begin
      res_data_r <= MAC_OUT;
    end else begin
      res_data_r <= res_data_r;
    end
  end

  // Port drive. The MAC strobes must be combinational with the accepted
  // beat so the product of that beat lands on the same clock edge.
  assign start_ready        = (state_r == S_IDLE);
  assign in_ready           = (state_r == S_RUN);
  assign busy               = (state_r != S_IDLE);
  assign res_valid          = (state_r == S_DONE);
  assign res_data           = res_data_r;

  assign MAC_OPER_DATA      = in_oper;
  assign MAC_COEF_DATA      = in_coef;
  assign EFPGA_MATHB_CLK_EN = accept_s;
  assign MAC_ACC_CLEAR      = first_beat_s & ~rnd_r;
  assign MAC_ACC_RND        = first_beat_s & rnd_r;
  assign MAC_ACC_SAT        = sat_r;
  assign MAC_OUT_SEL        = out_sel_r;
  assign MAC_TC             = tc_r;

endmodule

// File: tb/tb_mac8_dot_seq.sv
// Testbench for mac8_dot_seq: behavioural 8-bit MAC slice, expected results in a
// scoreboard queue pushed at job start and popped when res_valid appears.
`timescale 1ns/1ps
module tb_mac8_dot_seq;

  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start_valid = 1'b0;
  logic             start_ready;
  logic [LEN_W-1:0] cfg_len_m1 = '0;
  logic [5:0]       cfg_out_sel = 6'd0;
  logic             cfg_sat = 1'b0;
  logic             cfg_tc = 1'b0;
  logic             cfg_rnd = 1'b0;
  logic             abort = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       in_oper = 8'd0;
  logic [7:0]       in_coef = 8'd0;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [7:0]       res_data;
  logic             busy;
  logic [7:0]       mac_oper, mac_coef;
  logic             clk_en, acc_clear, acc_rnd, acc_sat, mac_tc;
  logic [5:0]       out_sel;
  logic [7:0]       mac_out;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] ops[4];
  logic [7:0] cfs[4];

  always #5 clk = ~clk;

  mac8_dot_seq #(.LEN_W(LEN_W)) dut (
    .MAC_ACC_CLK(clk), .MAC_ACC_RST(rst),
    .start_valid(start_valid), .start_ready(start_ready),
    .cfg_len_m1(cfg_len_m1), .cfg_out_sel(cfg_out_sel), .cfg_sat(cfg_sat),
    .cfg_tc(cfg_tc), .cfg_rnd(cfg_rnd), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_oper(in_oper), .in_coef(in_coef),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy),
    .MAC_OPER_DATA(mac_oper), .MAC_COEF_DATA(mac_coef),
    .EFPGA_MATHB_CLK_EN(clk_en), .MAC_ACC_CLEAR(acc_clear), .MAC_ACC_RND(acc_rnd),
    .MAC_ACC_SAT(acc_sat), .MAC_OUT_SEL(out_sel), .MAC_TC(mac_tc), .MAC_OUT(mac_out)
  );

  // ---------------- behavioural MAC slice ----------------
  logic [23:0]        acc = 24'd0;
  logic [5:0]         sel_q = 6'd0;
  logic signed [15:0] sprod;
  logic [15:0]        uprod;
  logic [23:0]        prod;
  logic [23:0]        seed;

  always_comb begin
    sprod = $signed(mac_oper) * $signed(mac_coef);
    uprod = mac_oper * mac_coef;
    prod  = mac_tc ? {{8{sprod[15]}}, sprod} : {8'd0, uprod};
    seed  = (out_sel == 6'd0) ? 24'd0 : (24'd1 << (out_sel - 6'd1));
  end

  // accumulator update; output select registered one cycle late like the real slice
  always @(posedge clk) begin
    sel_q <= out_sel;
    if (clk_en) begin
      if (acc_clear)    acc <= prod;
      else if (acc_rnd) acc <= seed + prod;
      else              acc <= acc + prod;
    end
  end

  logic signed [23:0] sh;
  always_comb begin
    sh = mac_tc ? ($signed(acc) >>> sel_q) : $signed(acc >> sel_q);
    mac_out = sh[7:0];
    if (acc_sat) begin
      if (mac_tc) begin
        if (sh > 24'sd127)       mac_out = 8'h7F;
        else if (sh < -24'sd128) mac_out = 8'h80;
      end else if (sh[23:8] != 16'd0) begin
        mac_out = 8'hFF;
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (clk_en !== 1'b0) begin n_fail++; $display("FAIL reset_clk_en: got %b expected 0", clk_en); end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    n_checks++; if (start_ready !== 1'b1) begin n_fail++; $display("FAIL reset_start_ready: got %b expected 1", start_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
    n_checks++; if (res_data !== 8'h00) begin n_fail++; $display("FAIL reset_res_data: got %h expected 00", res_data); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    n_checks++; if ({acc_clear, acc_rnd, acc_sat, mac_tc} !== 4'b0000) begin n_fail++; $display("FAIL reset_mac_ctl: got %b expected 0000", {acc_clear, acc_rnd, acc_sat, mac_tc}); end
    n_checks++; if (out_sel !== 6'd0) begin n_fail++; $display("FAIL reset_out_sel: got %0d expected 0", out_sel); end
  endtask

  // Runs one full job from ops/cfs, checks strobes per beat, latency and result.
  task automatic run_job(input int n, input logic [5:0] sel, input logic sat,
                         input logic tc, input logic rnd, input int gap,
                         input logic [7:0] expv, input int hold);
    logic [7:0] got, want, held;
    int waited;
    exp_q.push_back(expv);
    @(negedge clk);
    cfg_len_m1 = 8'(n - 1); cfg_out_sel = sel; cfg_sat = sat; cfg_tc = tc; cfg_rnd = rnd;
    start_valid = 1'b1;
    #1;
    n_checks++; if (start_ready !== 1'b1) begin n_fail++; $display("FAIL start_ready_idle: got %b expected 1", start_ready); end
    @(negedge clk);
    start_valid = 1'b0;
    // scramble the inputs: the job must run on the latched copy
    cfg_len_m1 = 8'hFF; cfg_out_sel = ~sel; cfg_sat = ~sat; cfg_tc = ~tc; cfg_rnd = ~rnd;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL in_ready_after_start: got %b expected 1", in_ready); end
    n_checks++; if ({out_sel, acc_sat, mac_tc} !== {sel, sat, tc}) begin n_fail++; $display("FAIL latched_cfg: got %h expected %h", {out_sel, acc_sat, mac_tc}, {sel, sat, tc}); end
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        #1;
        n_checks++; if ({clk_en, acc_clear, acc_rnd} !== 3'b000) begin n_fail++; $display("FAIL gap_strobes: got %b expected 000", {clk_en, acc_clear, acc_rnd}); end
        @(negedge clk);
      end
      in_valid = 1'b1; in_oper = ops[i]; in_coef = cfs[i];
      #1;
      n_checks++; if ({clk_en, acc_clear, acc_rnd} !== {1'b1, (i == 0) && !rnd, (i == 0) && rnd}) begin
        n_fail++; $display("FAIL beat%0d_strobes: got %b expected %b", i, {clk_en, acc_clear, acc_rnd}, {1'b1, (i == 0) && !rnd, (i == 0) && rnd});
      end
      n_checks++; if ({mac_oper, mac_coef} !== {ops[i], cfs[i]}) begin n_fail++; $display("FAIL beat%0d_mac_data: got %h expected %h", i, {mac_oper, mac_coef}, {ops[i], cfs[i]}); end
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    n_checks++; if ({clk_en, res_valid, busy, in_ready} !== 4'b0010) begin n_fail++; $display("FAIL drain_cycle: got %b expected 0010", {clk_en, res_valid, busy, in_ready}); end
    @(negedge clk);
    #1;
    n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL res_latency: got %b expected 1 two cycles after last beat", res_valid); end
    waited = 0;
    while (res_valid !== 1'b1 && waited < 10) begin @(negedge clk); #1; waited++; end
    if (res_valid !== 1'b1) begin n_checks++; n_fail++; $display("FAIL res_timeout: got res_valid=%b expected 1", res_valid); end
    want = exp_q.pop_front();
    got  = res_data;
    n_checks++; if (got !== want) begin n_fail++; $display("FAIL res_data: got %h expected %h", got, want); end
    held = res_data;
    for (int h = 0; h < hold; h++) begin
      start_valid = 1'b1;
      #1;
      n_checks++; if ({res_valid, start_ready, res_data} !== {2'b10, held}) begin n_fail++; $display("FAIL done_hold%0d: got %b_%h expected 10_%h", h, {res_valid, start_ready}, res_data, held); end
      @(negedge clk);
    end
    start_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    #1;
    n_checks++; if ({res_valid, start_ready, busy} !== 3'b010) begin n_fail++; $display("FAIL after_accept: got %b expected 010", {res_valid, start_ready, busy}); end
  endtask

  task automatic load_s1();
    ops[0] = 8'd3; cfs[0] = 8'd4;
    ops[1] = 8'd5; cfs[1] = 8'd6;
    ops[2] = 8'd1; cfs[2] = 8'd2;
  endtask

  task automatic test_unsigned_sum();
    load_s1();
    run_job(3, 6'd0, 1'b0, 1'b0, 1'b0, 0, 8'h2C, 0);
  endtask

  task automatic test_signed_sum();
    ops[0] = 8'hFD; cfs[0] = 8'd5;
    ops[1] = 8'd2;  cfs[1] = 8'd4;
    run_job(2, 6'd0, 1'b1, 1'b1, 1'b0, 0, 8'hF9, 0);
  endtask

  task automatic test_saturation();
    ops[0] = 8'd200; cfs[0] = 8'd200;
    run_job(1, 6'd0, 1'b1, 1'b0, 1'b0, 0, 8'hFF, 0);
    run_job(1, 6'd0, 1'b0, 1'b0, 1'b0, 0, 8'h40, 0);
  endtask

  task automatic test_rounding();
    ops[0] = 8'd10; cfs[0] = 8'd10;
    ops[1] = 8'd5;  cfs[1] = 8'd1;
    run_job(2, 6'd4, 1'b0, 1'b0, 1'b1, 0, 8'h07, 0);
    run_job(2, 6'd4, 1'b0, 1'b0, 1'b0, 0, 8'h06, 0);
  endtask

  task automatic test_flow_control();
    load_s1();
    run_job(3, 6'd0, 1'b0, 1'b0, 1'b0, 3, 8'h2C, 4);
  endtask

  // Kills a 4-term job after beat 1 by abort or by reset, then reruns scenario 1.
  task automatic test_abort(input logic use_rst);
    @(negedge clk);
    cfg_len_m1 = 8'd3; cfg_out_sel = 6'd4; cfg_sat = 1'b1; cfg_tc = 1'b1; cfg_rnd = 1'b0;
    start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_oper = 8'd7 + 8'(i); in_coef = 8'd9;
      @(negedge clk);
    end
    in_valid = 1'b1;
    if (use_rst) rst = 1'b1; else abort = 1'b1;
    #1;
    n_checks++; if ({clk_en, acc_clear, acc_rnd} !== 3'b000) begin n_fail++; $display("FAIL kill_strobes: got %b expected 000", {clk_en, acc_clear, acc_rnd}); end
    @(negedge clk);
    rst = 1'b0; abort = 1'b0; in_valid = 1'b0;
    #1;
    n_checks++; if ({busy, start_ready, res_valid} !== 3'b010) begin n_fail++; $display("FAIL kill_idle: got %b expected 010", {busy, start_ready, res_valid}); end
    if (use_rst) begin
      n_checks++; if ({out_sel, acc_sat, mac_tc, res_data} !== 16'h0000) begin n_fail++; $display("FAIL rst_zeroes_cfg: got %h expected 0000", {out_sel, acc_sat, mac_tc, res_data}); end
    end else begin
      n_checks++; if (res_data !== 8'h2C) begin n_fail++; $display("FAIL abort_keeps_res: got %h expected 2c", res_data); end
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL kill_no_result%0d: got %b expected 0", c, res_valid); end
    end
    load_s1();
    run_job(3, 6'd0, 1'b0, 1'b0, 1'b0, 0, 8'h2C, 0);
  endtask

  task automatic test_back_to_back();
    ops[0] = 8'd255; cfs[0] = 8'd255;
    run_job(1, 6'd8, 1'b0, 1'b0, 1'b0, 0, 8'hFE, 0);
    load_s1();
    run_job(3, 6'd0, 1'b0, 1'b0, 1'b0, 0, 8'h2C, 0);
  endtask

  initial begin
    test_reset();
    test_unsigned_sum();
    test_signed_sum();
    test_saturation();
    test_rounding();
    test_flow_control();
    test_abort(1'b0);
    test_abort(1'b1);
    test_back_to_back();
    if (exp_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // hard time limit so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
